// File: rtl/display_arbiter_pkg.sv
// Shared types and constants for the six-digit display arbiter.
package display_arbiter_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned NIBBLE_W   = 4;

  // Six nibbles; digit 5 in the top nibble, digit 0 in the bottom nibble.
  typedef logic [NUM_DIGITS*NIBBLE_W-1:0] digits_t;

  // Display ownership.
  typedef enum logic {
    HOST,
    OVL
  } state_t;

  // Counter width for a cycle count: $clog2 of the count, never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned v);
    int unsigned w;
    w = int'($clog2(v));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Bundle of the host/overlay request side and the display driver side.
interface display_arbiter_if;
  import display_arbiter_pkg::*;

  // Host PIO side
  digits_t                host_digits;
  logic                   host_valid;

  // Overlay requester side
  digits_t                ovl_digits;
  logic                   ovl_blink;
  logic                   ovl_req;
  logic                   ovl_ack;
  logic                   ovl_active;

  // Display driver side
  digits_t                digits_out;
  logic [NUM_DIGITS-1:0]  digits_blank;

  // Requesters and display drivers.
  modport master (
    output host_digits,
    output host_valid,
    output ovl_digits,
    output ovl_blink,
    output ovl_req,
    input  ovl_ack,
    input  ovl_active,
    input  digits_out,
    input  digits_blank
  );

  // The arbiter itself.
  modport slave (
    input  host_digits,
    input  host_valid,
    input  ovl_digits,
    input  ovl_blink,
    input  ovl_req,
    output ovl_ack,
    output ovl_active,
    output digits_out,
    output digits_blank
  );

endinterface

// File: rtl/display_arbiter_cycle_timer.sv
// Loadable down-counter with a zero flag; stops at zero rather than wrapping.
module cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Load has priority over decrement; reset clears the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/display_arbiter.sv
// Shares the six 7-segment digit drivers between the host PIO registers and a
// timed, optionally blinking overlay source. The host owns the display by
// default; an overlay request takes it for HOLD_CYCLES and then hands it back.
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned BLINK_HALF  = 12_500_000
) (
  input logic               clk,
  input logic               reset,
  display_arbiter_if.slave  io_bus
);

  localparam int unsigned HOLD_W  = cnt_width(HOLD_CYCLES);
  localparam int unsigned BLINK_W = cnt_width(BLINK_HALF);

  // Timers hold "cycles remaining minus one" so zero marks the last cycle.
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_HALF - 1);

  // State and shadow registers
  state_t                r_state;
  digits_t               r_host_shadow;
  digits_t               r_ovl_shadow;
  logic                  r_blink_en;
  logic                  r_phase_visible;

  // Registered outputs
  logic                  r_ovl_ack;
  logic                  r_ovl_active;
  digits_t               r_digits_out;
  logic [NUM_DIGITS-1:0] r_digits_blank;

  // Next-state values
  state_t                w_state_d;
  digits_t               w_host_shadow_d;
  digits_t               w_ovl_shadow_d;
  logic                  w_blink_en_d;
  logic                  w_phase_visible_d;
  logic                  w_show_ovl;

  // Timer controls
  logic                  w_hold_load;
  logic                  w_hold_dec;
  logic                  w_hold_zero;
  logic                  w_blink_load;
  logic                  w_blink_dec;
  logic                  w_blink_zero;

  cycle_timer #(
    .WIDTH (HOLD_W)
  ) u_hold_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_hold_load),
    .i_load_val (HOLD_LOAD),
    .i_dec      (w_hold_dec),
    .o_zero     (w_hold_zero)
  );

  cycle_timer #(
    .WIDTH (BLINK_W)
  ) u_blink_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_blink_load),
    .i_load_val (BLINK_LOAD),
    .i_dec      (w_blink_dec),
    .o_zero     (w_blink_zero)
  );

  // Next-state decode: a request (new or retrigger) always wins over hand-back.
  always_comb begin
    w_host_shadow_d   = io_bus.host_valid ? io_bus.host_digits : r_host_shadow;
    w_state_d         = r_state;
    w_ovl_shadow_d    = r_ovl_shadow;
    w_blink_en_d      = r_blink_en;
    w_phase_visible_d = r_phase_visible;
    w_hold_load       = 1'b0;
    w_hold_dec        = 1'b0;
    w_blink_load      = 1'b0;
    w_blink_dec       = 1'b0;

    if (io_bus.ovl_req) begin
      w_state_d         = OVL;
      w_ovl_shadow_d    = io_bus.ovl_digits;
      w_blink_en_d      = io_bus.ovl_blink;
      w_phase_visible_d = 1'b1;
      w_hold_load       = 1'b1;
      w_blink_load      = 1'b1;
    end else if (r_state == OVL) begin
      if (w_hold_zero) begin
        w_state_d = HOST;
      end else begin
        w_hold_dec = 1'b1;
      end
      // End of a blink half-period: flip the phase and start the next run.
      if (w_blink_zero) begin
        w_phase_visible_d = ~r_phase_visible;
        w_blink_load      = 1'b1;
      end else begin
        w_blink_dec = 1'b1;
      end
    end
  end

  assign w_show_ovl = (w_state_d == OVL);

  // State, shadows and outputs; outputs are built from next-state values so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= HOST;
      r_host_shadow   <= '0;
      r_ovl_shadow    <= '0;
      r_blink_en      <= 1'b0;
      r_phase_visible <= 1'b1;
      r_ovl_ack       <= 1'b0;
      r_ovl_active    <= 1'b0;
      r_digits_out    <= '0;
      r_digits_blank  <= '0;
    end else begin
      r_state         <= w_state_d;
      r_host_shadow   <= w_host_shadow_d;
      r_ovl_shadow    <= w_ovl_shadow_d;
      r_blink_en      <= w_blink_en_d;
      r_phase_visible <= w_phase_visible_d;
      r_ovl_ack       <= io_bus.ovl_req;
      r_ovl_active    <= w_show_ovl;
      r_digits_out    <= w_show_ovl ? w_ovl_shadow_d : w_host_shadow_d;
      r_digits_blank  <= {NUM_DIGITS{w_show_ovl & w_blink_en_d & ~w_phase_visible_d}};
    end
  end

  assign io_bus.ovl_ack      = r_ovl_ack;
  assign io_bus.ovl_active   = r_ovl_active;
  assign io_bus.digits_out   = r_digits_out;
  assign io_bus.digits_blank = r_digits_blank;

endmodule
